// File: rtl/pe_chain_array.sv
// pe_chain_array: LANES independent N-tap systolic MAC chains.
// Each lane computes o_psum = i_psum + sum_k w[k]*x[t-k] over its own delay line.
// Weights are loaded into a shadow bank and copied to the active bank on commit.
// Handshake: i_valid qualifies one sample per cycle on all lanes; there is no ready,
// every valid sample is accepted, and o_valid marks exactly one result per accepted
// sample, 2+D cycles later. o_psum/o_ovf hold their last value while o_valid is low.
module pe_chain_array #(
  parameter int XW    = 8,
  parameter int WW    = 8,
  parameter int BW1   = 16,
  parameter int N     = 4,
  parameter int LANES = 2,
  parameter int OW    = 16,
  parameter int D     = 0,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [LANES*XW-1:0]    i_x,
  input  logic [LANES*BW1-1:0]   i_psum,
  input  logic                   i_clr,
  input  logic                   i_sat,
  input  logic                   i_w_we,
  input  logic [LW-1:0]          i_w_lane,
  input  logic [IW-1:0]          i_w_idx,
  input  logic [WW-1:0]          i_w,
  input  logic                   i_w_commit,
  output logic                   o_valid,
  output logic [LANES*OW-1:0]    o_psum,
  output logic [LANES-1:0]       o_ovf
);

  localparam int PW = XW + WW;
  localparam int AW = ((BW1 > PW) ? BW1 : PW) + $clog2(N) + 1;
  // Extended width wide enough to hold both the accumulator and the OW limits.
  localparam int EW = ((AW > OW) ? AW : OW) + 1;
  localparam logic signed [EW-1:0] HI = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] LO = ~HI;

  logic signed [XW-1:0]  taps_q   [LANES][N];
  logic signed [XW-1:0]  taps_d   [LANES][N];
  logic signed [WW-1:0]  shadow_q [LANES][N];
  logic signed [WW-1:0]  shadow_d [LANES][N];
  logic signed [WW-1:0]  active_q [LANES][N];
  logic signed [PW-1:0]  prod_q   [LANES][N];
  logic signed [BW1-1:0] psum1_q  [LANES];
  logic                  v1_q;

  logic [LANES*OW-1:0]   res_c;
  logic [LANES-1:0]      ovf_c;
  logic                  v2_q;
  logic [LANES*OW-1:0]   psum2_q;
  logic [LANES-1:0]      ovf2_q;

  // Next delay-line state: clear first, then shift in the new sample on i_valid.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < N; k++) begin
        taps_d[l][k] = i_clr ? '0 : taps_q[l][k];
      end
      if (i_valid) begin
        taps_d[l][0] = signed'(i_x[l*XW +: XW]);
        for (int k = 1; k < N; k++) begin
          taps_d[l][k] = i_clr ? '0 : taps_q[l][k-1];
        end
      end
    end
  end

  // Next shadow bank: a same-cycle write is visible to a same-cycle commit.
  always_comb begin
    shadow_d = shadow_q;
    if (i_w_we && (32'(i_w_lane) < LANES) && (32'(i_w_idx) < N)) begin
      shadow_d[i_w_lane][i_w_idx] = signed'(i_w);
    end
  end

  // Delay lines, weight banks and stage 1 (products of post-shift taps and old active weights).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < N; k++) begin
          taps_q[l][k]   <= '0;
          shadow_q[l][k] <= '0;
          active_q[l][k] <= '0;
          prod_q[l][k]   <= '0;
        end
        psum1_q[l] <= '0;
      end
      v1_q <= 1'b0;
    end else begin
      taps_q   <= taps_d;
      shadow_q <= shadow_d;
      if (i_w_commit) begin
        active_q <= shadow_d;
      end
      v1_q <= i_valid;
      if (i_valid) begin
        for (int l = 0; l < LANES; l++) begin
          for (int k = 0; k < N; k++) begin
            prod_q[l][k] <= PW'(taps_d[l][k] * active_q[l][k]);
          end
          psum1_q[l] <= signed'(i_psum[l*BW1 +: BW1]);
        end
      end
    end
  end

  // Full-precision sum per lane, then saturate or wrap into OW bits and flag overflow.
  always_comb begin : sum_blk
    logic signed [AW-1:0] acc;
    logic signed [EW-1:0] sum_e;
    res_c = '0;
    ovf_c = '0;
    acc   = '0;
    sum_e = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = AW'(psum1_q[l]);
      for (int k = 0; k < N; k++) begin
        acc = acc + AW'(prod_q[l][k]);
      end
      sum_e = EW'(acc);
      ovf_c[l] = (sum_e > HI) || (sum_e < LO);
      if (i_sat && (sum_e > HI)) begin
        res_c[l*OW +: OW] = HI[OW-1:0];
      end else if (i_sat && (sum_e < LO)) begin
        res_c[l*OW +: OW] = LO[OW-1:0];
      end else begin
        res_c[l*OW +: OW] = sum_e[OW-1:0];
      end
    end
  end

  // Stage 2 registers: data only loads with a valid sample so it holds across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2_q    <= 1'b0;
      psum2_q <= '0;
      ovf2_q  <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        psum2_q <= res_c;
        ovf2_q  <= ovf_c;
      end
    end
  end

  generate
    if (D == 0) begin : g_no_rt
      assign o_valid = v2_q;
      assign o_psum  = psum2_q;
      assign o_ovf   = ovf2_q;
    end else begin : g_rt
      logic                rt_v    [D];
      logic [LANES*OW-1:0] rt_psum [D];
      logic [LANES-1:0]    rt_ovf  [D];

      // Output retiming chain; each stage holds its data while its valid is low.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < D; i++) begin
            rt_v[i]    <= 1'b0;
            rt_psum[i] <= '0;
            rt_ovf[i]  <= '0;
          end
        end else begin
          rt_v[0] <= v2_q;
          if (v2_q) begin
            rt_psum[0] <= psum2_q;
            rt_ovf[0]  <= ovf2_q;
          end
          for (int i = 1; i < D; i++) begin
            rt_v[i] <= rt_v[i-1];
            if (rt_v[i-1]) begin
              rt_psum[i] <= rt_psum[i-1];
              rt_ovf[i]  <= rt_ovf[i-1];
            end
          end
        end
      end

      assign o_valid = rt_v[D-1];
      assign o_psum  = rt_psum[D-1];
      assign o_ovf   = rt_ovf[D-1];
    end
  endgenerate

endmodule

// File: tb/tb_pe_chain_array.sv
// Directed bench for pe_chain_array (defaults: 2 lanes, 4 taps, D=0).
module tb_pe_chain_array;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_x = '0;
  logic [31:0] i_psum = '0;
  logic        i_clr = 1'b0;
  logic        i_sat = 1'b0;
  logic        i_w_we = 1'b0;
  logic [0:0]  i_w_lane = '0;
  logic [1:0]  i_w_idx = '0;
  logic [7:0]  i_w = '0;
  logic        i_w_commit = 1'b0;
  logic        o_valid;
  logic [31:0] o_psum;
  logic [1:0]  o_ovf;

  int total = 0;
  int bad = 0;

  // Expected entries: {ovf[1:0], lane1[15:0], lane0[15:0]}
  logic [33:0] exp_q[$];
  logic [33:0] last_exp = '0;
  logic [1:0]  vsh = '0;
  bit          mon_en = 1'b0;

  pe_chain_array dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x), .i_psum(i_psum),
    .i_clr(i_clr), .i_sat(i_sat), .i_w_we(i_w_we), .i_w_lane(i_w_lane),
    .i_w_idx(i_w_idx), .i_w(i_w), .i_w_commit(i_w_commit),
    .o_valid(o_valid), .o_psum(o_psum), .o_ovf(o_ovf)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output timing: a sample accepted at an edge shows up two edges later.
  always @(posedge i_clk) begin
    if (i_rst) vsh <= '0;
    else       vsh <= {vsh[0], i_valid};
  end

  // Scoreboard: o_valid timing every cycle, data on valid, hold value otherwise.
  always @(negedge i_clk) begin
    if (mon_en) begin
      check("o_valid", 34'(o_valid), 34'(vsh[1]));
      if (vsh[1]) begin
        check("exp_avail", 34'(exp_q.size() != 0), 34'd1);
        if (exp_q.size() != 0) last_exp = exp_q.pop_front();
        check("data", {o_ovf, o_psum}, last_exp);
      end else begin
        check("hold", {o_ovf, o_psum}, last_exp);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int lane, input int idx, input int val);
    i_w_we = 1'b1; i_w_lane = 1'(lane); i_w_idx = 2'(idx); i_w = 8'(val);
    step();
    i_w_we = 1'b0;
  endtask

  task automatic set_w(input int lane, input int w0, input int w1, input int w2, input int w3);
    wr(lane, 0, w0); wr(lane, 1, w1); wr(lane, 2, w2); wr(lane, 3, w3);
  endtask

  task automatic commit();
    i_w_commit = 1'b1;
    step();
    i_w_commit = 1'b0;
  endtask

  task automatic clr();
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic samp(input int x0, input int x1, input int p0, input int p1,
                      input int e0, input int e1, input logic [1:0] eo);
    i_valid = 1'b1;
    i_x = {8'(x1), 8'(x0)};
    i_psum = {16'(p1), 16'(p0)};
    exp_q.push_back({eo, 16'(e1), 16'(e0)});
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    bubble(2);
    i_rst = 1'b0;
    check("rst_valid", 34'(o_valid), 34'd0);
    check("rst_out", {o_ovf, o_psum}, 34'd0);
    mon_en = 1'b1;

    // Identity: lane0 w={1,0,0,0}
    wr(0, 0, 1);
    commit();
    samp(5, 0, 10, 0, 15, 0, 2'b00);
    check("lat_1cyc", 34'(o_valid), 34'd0);
    step();
    check("lat_2cyc", 34'(o_valid), 34'd1);
    check("ident", 34'(o_psum[15:0]), 34'd15);
    bubble(2);

    // FIR back-to-back, lane1 passes psum through (zero weights)
    set_w(0, 1, 2, 3, 4);
    commit();
    clr();
    samp(1, 0, 0, -3, 1, -3, 2'b00);
    samp(2, 0, 0, -3, 4, -3, 2'b00);
    samp(3, 0, 0, -3, 10, -3, 2'b00);
    samp(4, 0, 0, -3, 20, -3, 2'b00);
    bubble(3);

    // FIR with bubbles
    clr();
    samp(1, 0, 0, 7, 1, 7, 2'b00); bubble(1);
    samp(2, 0, 0, 7, 4, 7, 2'b00); bubble(1);
    samp(3, 0, 0, 7, 10, 7, 2'b00); bubble(1);
    samp(4, 0, 0, 7, 20, 7, 2'b00);
    bubble(3);

    // Saturation: lane0 positive overflow, lane1 negative overflow
    set_w(0, -128, -128, -128, -128);
    set_w(1, 127, 127, 127, 127);
    commit();
    clr();
    i_sat = 1'b1;
    samp(-128, -128, 100, -100, 16484, -16356, 2'b00);
    samp(-128, -128, 100, -100, 32767, -32612, 2'b01);
    samp(-128, -128, 100, -100, 32767, -32768, 2'b11);
    samp(-128, -128, 100, -100, 32767, -32768, 2'b11);
    bubble(3);
    i_sat = 1'b0;
    samp(-128, -128, 100, -100, 100, 412, 2'b11);
    bubble(3);

    // Commit timing: lane0 w all 1, lane1 x stays 0 after clear
    set_w(0, 1, 1, 1, 1);
    commit();
    clr();
    samp(1, 0, 0, 0, 1, 0, 2'b00);
    samp(1, 0, 0, 0, 2, 0, 2'b00);
    samp(1, 0, 0, 0, 3, 0, 2'b00);
    samp(1, 0, 0, 0, 4, 0, 2'b00);
    samp(1, 0, 0, 0, 4, 0, 2'b00);
    wr(0, 0, 2); wr(0, 1, 2); wr(0, 2, 2);
    i_w_we = 1'b1; i_w_lane = 1'b0; i_w_idx = 2'd3; i_w = 8'd2; i_w_commit = 1'b1;
    samp(1, 0, 0, 0, 4, 0, 2'b00);
    i_w_we = 1'b0; i_w_commit = 1'b0;
    samp(1, 0, 0, 0, 8, 0, 2'b00);
    bubble(3);

    // Clear and independent lanes
    set_w(0, 1, 1, 1, 1);
    set_w(1, 2, 2, 2, 2);
    commit();
    clr();
    samp(3, 3, 0, 0, 3, 6, 2'b00);
    samp(3, 3, 0, 0, 6, 12, 2'b00);
    samp(3, 3, 0, 0, 9, 18, 2'b00);
    samp(3, 3, 0, 0, 12, 24, 2'b00);
    i_clr = 1'b1;
    samp(3, 3, 0, 0, 3, 6, 2'b00);
    i_clr = 1'b0;
    bubble(3);

    // Reset mid-stream: second sample is still in flight when reset hits
    samp(1, 1, 0, 0, 4, 8, 2'b00);
    samp(1, 1, 0, 0, 5, 10, 2'b00);
    i_rst = 1'b1;
    step();
    exp_q.delete();
    last_exp = '0;
    check("midrst_valid", 34'(o_valid), 34'd0);
    check("midrst_out", {o_ovf, o_psum}, 34'd0);
    step();
    i_rst = 1'b0;
    samp(1, 1, 10, -20, 10, -20, 2'b00);
    bubble(1);
    commit();
    samp(1, 1, 33, 44, 33, 44, 2'b00);
    bubble(3);
    check("drain", 34'(exp_q.size()), 34'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_chain_array.md
Name: pe_chain_array

Overview:
- Multi-lane, parametrised successor to the single processing-element chain.
- Each of LANES independent lanes is an N-tap systolic MAC chain. Every lane keeps its own input delay line and computes o_psum = i_psum + sum over k of w[k]*x[t-k].
- Adds valid qualification, double-buffered runtime weight loading, output saturate/wrap mode, per-lane overflow flag and tap clear.
- Sits between the activation streamer and the partial-sum collector of the convolution datapath.

Parameters:
- XW, 8, signed activation width
- WW, 8, signed weight width
- BW1, 16, signed input psum width
- N, 4, taps per lane (>=1)
- LANES, 2, independent lanes (>=1)
- OW, 16, signed output psum width
- D, 0, extra output retiming stages (>=0)
- Localparam AW = max(BW1, XW+WW) + clog2(N) + 1, the internal full-precision accumulator width.

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  sample valid for all lanes
- i_x  in  LANES*XW  packed signed activations; lane l = bits [l*XW +: XW]
- i_psum  in  LANES*BW1  packed signed incoming partial sums
- i_clr  in  1  clear all lane delay lines (weights kept)
- i_sat  in  1  1 = saturate output to OW range, 0 = wrap (keep low OW bits)
- i_w_we  in  1  write one shadow weight
- i_w_lane  in  clog2(LANES) (min 1)  shadow write lane index
- i_w_idx  in  clog2(N) (min 1)  shadow write tap index
- i_w  in  WW  signed weight data
- i_w_commit  in  1  copy whole shadow bank to active bank
- o_valid  out  1  output valid
- o_psum  out  LANES*OW  packed signed output partial sums
- o_ovf  out  LANES  per-lane overflow flag, qualified by o_valid

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - Clears delay lines, both weight banks, all pipeline registers, o_valid, o_psum and o_ovf to 0.
  - Any in-flight samples are discarded, so o_valid is 0 on the cycle after reset.
- Delay line, per lane, taps x[0..N-1]:
  - On i_valid, x[0] <= lane i_x and x[k] <= x[k-1].
  - Without i_valid, the taps hold; bubbles never shift the line.
- Clear:
  - i_clr zeroes all taps.
  - If i_clr and i_valid are both high, the clear applies first: x[0] <= i_x and all other taps become 0.
  - Output for that sample uses the new tap values.
- Pipeline stage 1 (cycle after i_valid):
  - Registers N signed products w_active[k]*tap[k], each XW+WW wide.
  - Uses tap values after the shift, i.e. including the new sample.
  - Registers the lane psum alongside.
- Pipeline stage 2:
  - Registers a signed sum of all products plus sign-extended psum at AW bits; this never overflows internally.
  - Applies the output mode:
    - i_sat=1: clamp to [-2^(OW-1), 2^(OW-1)-1].
    - i_sat=0: take the low OW bits.
  - i_sat is sampled at stage 2.
  - o_ovf[l]=1 when the AW-bit sum lies outside the OW signed range, in either mode.
- Latency:
  - o_valid, o_psum and o_ovf appear exactly 2+D cycles after the i_valid edge.
  - Throughput is one sample per cycle; there is no backpressure.
- Output hold:
  - o_psum and o_ovf hold their last value while o_valid=0.
  - o_ovf is only meaningful when o_valid=1.
- Weight write:
  - i_w_we writes shadow[i_w_lane][i_w_idx] <= i_w.
  - Out-of-range lane or tap indices are ignored.
- Commit:
  - i_w_commit copies the shadow bank to the active bank at the edge, affecting samples whose i_valid is on the next cycle or later.
  - A sample with i_valid in the same cycle as the commit uses the old weights.
  - If i_w_we and i_w_commit are in the same cycle, the written value is included in the commit.
- Weight safety: samples already in the pipeline are never affected by later writes or commits.
- Lanes share control signals (i_valid, i_clr, i_sat, commit) and are otherwise fully independent.

Test Plan:
- Reset/identity: lane0 w={1,0,0,0}, commit; i_x lane0=5, i_psum lane0=10, one i_valid -> o_valid exactly 2+D cycles later, o_psum lane0=15, o_ovf=0.
- FIR: lane0 w={1,2,3,4}, psum=0; x=1,2,3,4 on consecutive cycles -> outputs 1,4,10,20 back-to-back. Repeat with one-cycle bubbles between samples -> same values; o_valid shows the same gaps.
- Saturation: all taps x=-128, w=-128, psum=100 (sum 65636) -> i_sat=1 gives 32767 with o_ovf=1; i_sat=0 gives 100 with o_ovf=1.
- Commit timing: stream constant x=1 with w bank all 1 (outputs 4 once the line is full); write shadow all 2 and commit on the same cycle as an i_valid -> that sample outputs 4; the next sample outputs 8.
- Clear and lanes: lane0 w={1,1,1,1}, lane1 w={2,2,2,2}; feed x=3 four times -> lane0=12, lane1=24. Assert i_clr with i_valid, x=3 -> lane0=3, lane1=6.
- Reset mid-stream: assert i_rst while samples are in flight -> o_valid=0 and o_psum=0 next cycle. After release, feeding x=1 with no commit -> output equals psum (weights were cleared to 0).
